// File: rtl/pipeline_pkg.sv
// Shared constants and helpers for the pipeline stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipeline_pkg;

   localparam int unsigned DEF_ADDR_W   = 64;
   localparam int unsigned DEF_INSTR_W  = 32;
   localparam logic [31:0] DEF_NOP_INSN = 32'h0000_0013;  // addi x0,x0,0
   localparam logic        RST_VALID    = 1'b0;

   typedef enum logic [1:0] {
      ActLoad,
      ActStall,
      ActFlush
   } stage_action_e;

   // Flush beats stall, stall beats load.
   function automatic stage_action_e stage_action(input logic flush, input logic write);
      if (flush) begin
         return ActFlush;
      end else if (!write) begin
         return ActStall;
      end
      return ActLoad;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter with asynchronous active-low clear that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/if_id_pipeline_register.sv
// IF/ID stage register: captures fetch PC/instruction, holds on stall, inserts a NOP bubble on flush,
// and keeps saturating stall/flush event counters for debug.
module if_id_pipeline_register
   import pipeline_pkg::*;
#(
   parameter int unsigned          ADDR_W   = DEF_ADDR_W,
   parameter int unsigned          INSTR_W  = DEF_INSTR_W,
   parameter int unsigned          CNT_W    = 16,
   parameter logic [INSTR_W-1:0]   NOP_INSN = INSTR_W'(DEF_NOP_INSN)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pc_in,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               if_id_write,
   input  logic               flush,
   output logic [ADDR_W-1:0]  pc_out,
   output logic [INSTR_W-1:0] instr_out,
   output logic               valid_out,
   output logic [CNT_W-1:0]   stall_count,
   output logic [CNT_W-1:0]   flush_count
);

   stage_action_e action;
   logic          stall_evt;
   logic          flush_evt;

   always_comb begin
      action    = stage_action(flush, if_id_write);
      stall_evt = (action == ActStall);
      flush_evt = (action == ActFlush);
   end

   // The bubble is a constant, so whatever is on instr_in during a flush never reaches decode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_out    <= '0;
         instr_out <= NOP_INSN;
         valid_out <= RST_VALID;
      end else begin
         unique case (action)
            ActFlush: begin
               pc_out    <= pc_in;
               instr_out <= NOP_INSN;
               valid_out <= 1'b0;
            end
            ActLoad: begin
               pc_out    <= pc_in;
               instr_out <= instr_in;
               valid_out <= 1'b1;
            end
            default: ;  // stall: hold everything, including a held bubble's valid=0
         endcase
      end
   end

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (stall_evt),
      .count(stall_count)
   );

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_flush_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (flush_evt),
      .count(flush_count)
   );

endmodule

// File: tb/tb_if_id_pipeline_register.sv
// Bench for if_id_pipeline_register: directed vector table, hand-written corner sequences and a
// randomized run against a behavioural model. Counters are 4 bits wide so saturation is reachable.
module tb_if_id_pipeline_register;

   localparam int unsigned CW  = 4;
   localparam int          SAT = 15;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic [63:0] pc_in;
   logic [31:0] instr_in;
   logic        if_id_write;
   logic        flush;
   logic [63:0] pc_out;
   logic [31:0] instr_out;
   logic        valid_out;
   logic [CW-1:0] stall_count;
   logic [CW-1:0] flush_count;

   int checks;
   int errors;

   if_id_pipeline_register #(
      .ADDR_W (64),
      .INSTR_W(32),
      .CNT_W  (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pc_in      (pc_in),
      .instr_in   (instr_in),
      .if_id_write(if_id_write),
      .flush      (flush),
      .pc_out     (pc_out),
      .instr_out  (instr_out),
      .valid_out  (valid_out),
      .stall_count(stall_count),
      .flush_count(flush_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        flush;
      logic        write;
      logic [63:0] pc;
      logic [31:0] instr;
      logic [63:0] e_pc;
      logic [31:0] e_instr;
      logic        e_valid;
      int          e_stall;
      int          e_flush;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic [63:0] e_pc, input logic [31:0] e_instr,
                            input logic e_valid, input int e_stall, input int e_flush);
      check({tag, ".pc_out"}, pc_out, e_pc);
      check({tag, ".instr_out"}, {32'h0, instr_out}, {32'h0, e_instr});
      check({tag, ".valid_out"}, {63'h0, valid_out}, {63'h0, e_valid});
      check({tag, ".stall_count"}, 64'(stall_count), 64'(e_stall));
      check({tag, ".flush_count"}, 64'(flush_count), 64'(e_flush));
   endtask

   // Advance one rising edge and settle just past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic fl, input logic wr, input logic [63:0] pc,
                        input logic [31:0] ins);
      flush       = fl;
      if_id_write = wr;
      pc_in       = pc;
      instr_in    = ins;
   endtask

   // Assert reset mid-cycle, check immediately (no edge), hold over an edge, release.
   task automatic mid_cycle_reset(input string tag);
      #2;
      reset = 1'b0;
      #1;
      check_all(tag, 64'h0, NOP, 1'b0, 0, 0);
      step();
      reset = 1'b1;
   endtask

   // Behavioural model state
   logic [63:0] m_pc;
   logic [31:0] m_instr;
   logic        m_valid;
   int          m_stall;
   int          m_flush;

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      drive(1'b0, 1'b1, 64'h0, 32'h0);

      vecs[0] = '{1'b0, 1'b1, 64'h10, 32'h00A2_8293, 64'h10, 32'h00A2_8293, 1'b1, 0, 0};
      vecs[1] = '{1'b0, 1'b0, 64'h14, 32'hDEAD_BEEF, 64'h10, 32'h00A2_8293, 1'b1, 1, 0};
      vecs[2] = '{1'b0, 1'b0, 64'h14, 32'hDEAD_BEEF, 64'h10, 32'h00A2_8293, 1'b1, 2, 0};
      vecs[3] = '{1'b0, 1'b0, 64'h14, 32'hDEAD_BEEF, 64'h10, 32'h00A2_8293, 1'b1, 3, 0};
      vecs[4] = '{1'b1, 1'b0, 64'h18, 32'hFFFF_FFFF, 64'h18, NOP, 1'b0, 3, 1};
      vecs[5] = '{1'b0, 1'b0, 64'h1C, 32'h1111_1111, 64'h18, NOP, 1'b0, 4, 1};
      vecs[6] = '{1'b0, 1'b0, 64'h1C, 32'h2222_2222, 64'h18, NOP, 1'b0, 5, 1};
      vecs[7] = '{1'b0, 1'b1, 64'h20, 32'h0000_0033, 64'h20, 32'h0000_0033, 1'b1, 5, 1};
      vecs[8] = '{1'b1, 1'b1, 64'h24, 32'h1234_5678, 64'h24, NOP, 1'b0, 5, 2};

      // Reset state while held
      step();
      step();
      check_all("reset_hold", 64'h0, NOP, 1'b0, 0, 0);
      reset = 1'b1;

      // Get non-reset contents, then async reset with pc_in=0x40 mid-cycle
      drive(1'b0, 1'b1, 64'h40, 32'h0000_0093);
      step();
      check_all("pre_async_load", 64'h40, 32'h0000_0093, 1'b1, 0, 0);
      drive(1'b0, 1'b0, 64'h40, 32'h0000_0093);
      step();
      drive(1'b1, 1'b0, 64'h40, 32'h0000_0093);
      step();
      check_all("pre_async_flush", 64'h40, NOP, 1'b0, 1, 1);
      mid_cycle_reset("async_reset");

      // Directed table
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].flush, vecs[i].write, vecs[i].pc, vecs[i].instr);
         step();
         check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_valid,
                   vecs[i].e_stall, vecs[i].e_flush);
      end

      // Stall saturation: 20 stall edges from stall_count=5
      drive(1'b0, 1'b0, 64'h28, 32'hAAAA_AAAA);
      for (int i = 0; i < 20; i++) step();
      check_all("stall_sat", 64'h24, NOP, 1'b0, SAT, 2);
      drive(1'b0, 1'b1, 64'h2C, 32'h0000_0113);
      step();
      check_all("load_after_sat", 64'h2C, 32'h0000_0113, 1'b1, SAT, 2);
      drive(1'b1, 1'b1, 64'h30, 32'h0000_0113);
      for (int i = 0; i < 20; i++) step();
      check_all("flush_sat", 64'h30, NOP, 1'b0, SAT, SAT);

      // Reset mid-stall: nothing pending survives
      mid_cycle_reset("reset_after_sat");
      drive(1'b0, 1'b1, 64'h50, 32'h0000_0193);
      step();
      drive(1'b0, 1'b0, 64'h54, 32'h0000_0213);
      step();
      mid_cycle_reset("reset_mid_stall");
      drive(1'b0, 1'b0, 64'h58, 32'h0000_0293);
      step();
      check_all("stall_after_reset", 64'h0, NOP, 1'b0, 1, 0);

      // Unknown instruction data under flush must yield the exact bubble
      flush       = 1'b1;
      if_id_write = 1'b1;
      pc_in       = 64'h5C;
      instr_in    = 'x;
      step();
      check_all("flush_x_instr", 64'h5C, NOP, 1'b0, 1, 1);

      // Randomized run against the model
      mid_cycle_reset("reset_before_rand");
      m_pc    = 64'h0;
      m_instr = NOP;
      m_valid = 1'b0;
      m_stall = 0;
      m_flush = 0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 59) == 0) begin
            mid_cycle_reset($sformatf("rand_reset%0d", c));
            m_pc    = 64'h0;
            m_instr = NOP;
            m_valid = 1'b0;
            m_stall = 0;
            m_flush = 0;
         end
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, {$urandom, $urandom},
               $urandom);
         step();
         if (flush) begin
            m_pc    = pc_in;
            m_instr = NOP;
            m_valid = 1'b0;
            m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
         end else if (!if_id_write) begin
            m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
         end else begin
            m_pc    = pc_in;
            m_instr = instr_in;
            m_valid = 1'b1;
         end
         check_all($sformatf("rand%0d", c), m_pc, m_instr, m_valid, m_stall, m_flush);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
